// File: rtl/av2_intra_ref_builder_pkg.sv
// Shared definitions for the AV2 intra reference builder and the predictor:
// sample geometry, FSM encoding, availability flags and the padding selector.
package av2_intra_pkg;

  localparam int BIT_DEPTH = 10;
  localparam int REF_LEN   = 128;
  localparam int MID       = 1 << (BIT_DEPTH - 1);

  typedef logic [BIT_DEPTH-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_TL,
    ST_LOAD_TOP,
    ST_LOAD_TR,
    ST_LOAD_LEFT,
    ST_LOAD_BL,
    ST_PAD,
    ST_DONE
  } av2_state_e;

  // tr and bl are the effective flags (already gated by top / left).
  typedef struct packed {
    logic tl;
    logic top;
    logic tr;
    logic left;
    logic bl;
  } av2_flags_t;

  // 6-bit block dimension to sample count; 0 stands for 64.
  function automatic logic [6:0] av2_dim_decode(input logic [5:0] d);
    return (d == 6'd0) ? 7'd64 : {1'b0, d};
  endfunction

  // First enabled LOAD state strictly after s in stream order, or PAD.
  function automatic av2_state_e av2_next_load(input av2_state_e s, input av2_flags_t f);
    av2_state_e n;
    n = ST_PAD;
    if (s == ST_IDLE && f.tl) begin
      n = ST_LOAD_TL;
    end else if ((s inside {ST_IDLE, ST_LOAD_TL}) && f.top) begin
      n = ST_LOAD_TOP;
    end else if ((s inside {ST_IDLE, ST_LOAD_TL, ST_LOAD_TOP}) && f.tr) begin
      n = ST_LOAD_TR;
    end else if ((s inside {ST_IDLE, ST_LOAD_TL, ST_LOAD_TOP, ST_LOAD_TR}) && f.left) begin
      n = ST_LOAD_LEFT;
    end else if ((s inside {ST_IDLE, ST_LOAD_TL, ST_LOAD_TOP, ST_LOAD_TR, ST_LOAD_LEFT}) && f.bl) begin
      n = ST_LOAD_BL;
    end
    return n;
  endfunction

  // Padded value for one reference array entry. 'hold' is the entry written
  // at idx-1; every non-streamed entry at idx >= dim replicates its lower
  // neighbour, so the previous write is exactly the required source.
  function automatic sample_t av2_ref_pad_sel(
    input logic [6:0] idx,
    input logic [6:0] dim,
    input logic       avail_main,
    input logic       avail_ext,
    input sample_t    raw,
    input logic       avail_other,
    input sample_t    other_raw0,
    input sample_t    hold
  );
    logic [7:0] i8;
    logic [7:0] dim2;
    sample_t    v;
    i8   = {1'b0, idx};
    dim2 = {dim, 1'b0};
    if (i8 < {1'b0, dim}) begin
      if (avail_main)       v = raw;
      else if (avail_other) v = other_raw0;
      else                  v = sample_t'(MID);
    end else if (i8 < dim2 && avail_ext) begin
      v = raw;
    end else begin
      v = hold;
    end
    return v;
  endfunction

endpackage

// File: rtl/av2_intra_ref_builder.sv
// Collects streamed neighbour samples of a block, pads unavailable regions
// and hands complete top/left/corner reference arrays to the intra predictor.
//
// Handshakes: a neighbour sample moves on a clock edge where nb_valid and
// nb_ready are both high; the reference arrays move on an edge where
// out_valid and out_ready are both high. Once raised, out_valid stays high
// with the arrays unchanged until that edge; nb_ready is high only while a
// LOAD state is active.
module av2_intra_ref_builder
  import av2_intra_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [5:0]           block_width,
  input  logic [5:0]           block_height,
  input  logic                 avail_top,
  input  logic                 avail_topright,
  input  logic                 avail_left,
  input  logic                 avail_bottomleft,
  input  logic                 avail_topleft,
  input  logic [BIT_DEPTH-1:0] nb_data,
  input  logic                 nb_valid,
  output logic                 nb_ready,
  output logic [BIT_DEPTH-1:0] ref_top [REF_LEN],
  output logic [BIT_DEPTH-1:0] ref_left [REF_LEN],
  output logic [BIT_DEPTH-1:0] ref_top_left,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output av2_state_e           dbg_state
);

  av2_state_e state_q, state_d;
  logic [6:0] cnt_q;
  logic [6:0] w_q, h_q;
  av2_flags_t flags_q, flags_in;
  logic       nb_ready_q, out_valid_q, busy_q;

  sample_t    tl_raw_q;
  sample_t    top_raw_q  [REF_LEN];
  sample_t    left_raw_q [REF_LEN];
  sample_t    hold_top_q, hold_left_q;

  logic       xfer;
  logic       load_last;
  logic [6:0] load_len;
  logic [6:0] raw_addr;
  sample_t    pad_top, pad_left, pad_tl;

  assign flags_in = '{tl:   avail_topleft,
                      top:  avail_top,
                      tr:   avail_topright & avail_top,
                      left: avail_left,
                      bl:   avail_bottomleft & avail_left};

  assign xfer      = nb_valid & nb_ready_q;
  assign nb_ready  = nb_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

  // Sample count and raw write address of the active LOAD state.
  always_comb begin
    load_len = 7'd1;
    raw_addr = cnt_q;
    case (state_q)
      ST_LOAD_TOP:  load_len = w_q;
      ST_LOAD_TR: begin
        load_len = w_q;
        raw_addr = w_q + cnt_q;
      end
      ST_LOAD_LEFT: load_len = h_q;
      ST_LOAD_BL: begin
        load_len = h_q;
        raw_addr = h_q + cnt_q;
      end
      default: ;
    endcase
    load_last = xfer && (cnt_q == load_len - 7'd1);
  end

  // Next-state selection; disabled LOAD states are skipped in zero cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = av2_next_load(ST_IDLE, flags_in);
      ST_LOAD_TL, ST_LOAD_TOP, ST_LOAD_TR, ST_LOAD_LEFT, ST_LOAD_BL:
        if (load_last) state_d = av2_next_load(state_q, flags_q);
      ST_PAD:  if (cnt_q == 7'(REF_LEN - 1)) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Padded values for the entry at cnt_q during PAD.
  always_comb begin
    pad_top  = av2_ref_pad_sel(cnt_q, w_q, flags_q.top, flags_q.tr, top_raw_q[cnt_q],
                               flags_q.left, left_raw_q[0], hold_top_q);
    pad_left = av2_ref_pad_sel(cnt_q, h_q, flags_q.left, flags_q.bl, left_raw_q[cnt_q],
                               flags_q.top, top_raw_q[0], hold_left_q);
    if (flags_q.tl)        pad_tl = tl_raw_q;
    else if (flags_q.top)  pad_tl = top_raw_q[0];
    else if (flags_q.left) pad_tl = left_raw_q[0];
    else                   pad_tl = sample_t'(MID);
  end

  // Raw sample capture; contents only matter where a flag marks them loaded.
  always_ff @(posedge clk) begin
    if (xfer) begin
      case (state_q)
        ST_LOAD_TL:              tl_raw_q             <= nb_data;
        ST_LOAD_TOP, ST_LOAD_TR: top_raw_q[raw_addr]  <= nb_data;
        ST_LOAD_LEFT, ST_LOAD_BL: left_raw_q[raw_addr] <= nb_data;
        default: ;
      endcase
    end
  end

  // FSM, counter, registered handshake outputs and padded reference arrays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      flags_q      <= '0;
      nb_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      hold_top_q   <= '0;
      hold_left_q  <= '0;
      ref_top_left <= '0;
      for (int i = 0; i < REF_LEN; i++) begin
        ref_top[i]  <= '0;
        ref_left[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      nb_ready_q  <= (state_d inside {ST_LOAD_TL, ST_LOAD_TOP, ST_LOAD_TR,
                                      ST_LOAD_LEFT, ST_LOAD_BL});
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);

      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (xfer || state_q == ST_PAD) begin
        cnt_q <= cnt_q + 7'd1;
      end

      if (state_q == ST_IDLE && start) begin
        w_q     <= av2_dim_decode(block_width);
        h_q     <= av2_dim_decode(block_height);
        flags_q <= flags_in;
      end

      if (state_q == ST_PAD) begin
        ref_top[cnt_q]  <= pad_top;
        ref_left[cnt_q] <= pad_left;
        hold_top_q      <= pad_top;
        hold_left_q     <= pad_left;
        if (cnt_q == 7'd0) ref_top_left <= pad_tl;
      end
    end
  end

endmodule

// File: tb/tb_av2_intra_ref_builder.sv
// Directed bench for av2_intra_ref_builder: hand-derived reference arrays,
// latency and handshake behaviour for a sequence of block scenarios.
module tb_av2_intra_ref_builder;
  import av2_intra_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [5:0]           block_width, block_height;
  logic                 avail_top, avail_topright, avail_left, avail_bottomleft, avail_topleft;
  logic [BIT_DEPTH-1:0] nb_data;
  logic                 nb_valid;
  logic                 nb_ready;
  logic [BIT_DEPTH-1:0] ref_top [REF_LEN];
  logic [BIT_DEPTH-1:0] ref_left [REF_LEN];
  logic [BIT_DEPTH-1:0] ref_top_left;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  av2_state_e           dbg_state;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  sample_t exp_top  [REF_LEN];
  sample_t exp_left [REF_LEN];
  sample_t exp_tl;
  sample_t stim_q [$];

  // clock / reset block
  always #5 clk = ~clk;

  av2_intra_ref_builder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .block_width      (block_width),
    .block_height     (block_height),
    .avail_top        (avail_top),
    .avail_topright   (avail_topright),
    .avail_left       (avail_left),
    .avail_bottomleft (avail_bottomleft),
    .avail_topleft    (avail_topleft),
    .nb_data          (nb_data),
    .nb_valid         (nb_valid),
    .nb_ready         (nb_ready),
    .ref_top          (ref_top),
    .ref_left         (ref_left),
    .ref_top_left     (ref_top_left),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compares each array at its first differing index (index 0 if all agree).
  task automatic check_arrays(input string tag);
    int bt;
    int bl;
    bt = 0;
    bl = 0;
    for (int i = REF_LEN - 1; i >= 0; i--) begin
      if (ref_top[i] !== exp_top[i])   bt = i;
      if (ref_left[i] !== exp_left[i]) bl = i;
    end
    check({tag, ".ref_top"},  ref_top[bt],  exp_top[bt]);
    check({tag, ".ref_left"}, ref_left[bl], exp_left[bl]);
    check({tag, ".corner"},   ref_top_left, exp_tl);
  endtask

  task automatic set_zero_exp();
    for (int i = 0; i < REF_LEN; i++) begin
      exp_top[i]  = '0;
      exp_left[i] = '0;
    end
    exp_tl = '0;
  endtask

  task automatic load_s1_stim_exp();
    stim_q = {};
    stim_q.push_back(sample_t'(100));
    for (int i = 0; i < 8; i++) stim_q.push_back(sample_t'(200 + i));
    for (int i = 0; i < 8; i++) stim_q.push_back(sample_t'(300 + i));
    for (int i = 0; i < REF_LEN; i++) begin
      exp_top[i]  = sample_t'((i < 8) ? 200 + i : 207);
      exp_left[i] = sample_t'((i < 8) ? 300 + i : 307);
    end
    exp_tl = sample_t'(100);
  endtask

  // Driver: starts one block, streams stim_q (alt=1 drives nb_valid every
  // other cycle), checks latency, then holds out_ready low for 'hold' cycles.
  task automatic run_block(input string tag, input int w, input int h,
                           input logic [4:0] fl, input bit alt,
                           input int exp_lat, input int hold, input bit start_in_done);
    int lat;
    int ready_cycles;
    bit tog;
    bit prev;
    block_width      = 6'(w);
    block_height     = 6'(h);
    avail_topleft    = fl[4];
    avail_top        = fl[3];
    avail_topright   = fl[2];
    avail_left       = fl[1];
    avail_bottomleft = fl[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_after_start"}, busy, 1);
    lat = 1;
    ready_cycles = 0;
    tog = 1'b0;
    prev = 1'b0;
    while (!out_valid && lat < 400) begin
      if (prev) void'(stim_q.pop_front());
      nb_valid = (stim_q.size() > 0) && (!alt || tog);
      nb_data  = (stim_q.size() > 0) ? stim_q[0] : '0;
      prev = nb_valid && nb_ready;
      if (nb_ready) ready_cycles++;
      tog = ~tog;
      @(negedge clk);
      lat++;
    end
    nb_valid = 1'b0;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".ready_cycles"}, ready_cycles, exp_lat - 1 - REF_LEN);
    check({tag, ".stream_consumed"}, stim_q.size(), 0);
    out_ready = 1'b0;
    check_arrays(tag);
    for (int k = 0; k < hold; k++) begin
      start = (start_in_done && k == 1);
      @(negedge clk);
      check({tag, ".hold_valid"}, out_valid, 1);
    end
    start = 1'b0;
    if (hold > 0) check_arrays({tag, ".held"});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_dropped"}, out_valid, 0);
    check({tag, ".busy_dropped"}, busy, 0);
    check({tag, ".state_idle"}, dbg_state, ST_IDLE);
    @(negedge clk);
    check({tag, ".still_idle"}, busy, 0);
    check_arrays({tag, ".kept"});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    block_width = '0;
    block_height = '0;
    avail_top = 1'b0;
    avail_topright = 1'b0;
    avail_left = 1'b0;
    avail_bottomleft = 1'b0;
    avail_topleft = 1'b0;
    nb_data = '0;
    nb_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("reset.nb_ready", nb_ready, 0);
    check("reset.out_valid", out_valid, 0);
    check("reset.busy", busy, 0);
    check("reset.state", dbg_state, ST_IDLE);
    set_zero_exp();
    check_arrays("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 4x4, all flags, continuous stream
    load_s1_stim_exp();
    run_block("s1", 4, 4, 5'b11111, 1'b0, 146, 0, 1'b0);

    // 2: 8x8, nothing available -> everything MID, no stream
    stim_q = {};
    for (int i = 0; i < REF_LEN; i++) begin
      exp_top[i]  = sample_t'(512);
      exp_left[i] = sample_t'(512);
    end
    exp_tl = sample_t'(512);
    run_block("s2", 8, 8, 5'b00000, 1'b0, 129, 0, 1'b0);

    // 3: 4x4, left only
    stim_q = {sample_t'(10), sample_t'(20), sample_t'(30), sample_t'(40)};
    for (int i = 0; i < REF_LEN; i++) begin
      exp_top[i]  = sample_t'(10);
      exp_left[i] = sample_t'((i < 4) ? 10 * (i + 1) : 40);
    end
    exp_tl = sample_t'(10);
    run_block("s3", 4, 4, 5'b00010, 1'b0, 133, 0, 1'b0);

    // 6: width 64 (encoded 0), height 4, top + topright
    stim_q = {};
    for (int i = 0; i < REF_LEN; i++) stim_q.push_back(sample_t'(i));
    for (int i = 0; i < REF_LEN; i++) begin
      exp_top[i]  = sample_t'(i);
      exp_left[i] = '0;
    end
    exp_tl = '0;
    run_block("s6", 0, 4, 5'b01100, 1'b0, 257, 0, 1'b0);

    // 4: scenario 1 with 50% nb_valid, out_ready late, start during DONE
    load_s1_stim_exp();
    run_block("s4", 4, 4, 5'b11111, 1'b1, 163, 5, 1'b1);

    // 5: reset in LOAD_TOP after corner + 3 top samples
    block_width = 6'd4;
    block_height = 6'd4;
    avail_topleft = 1'b1;
    avail_top = 1'b1;
    avail_topright = 1'b1;
    avail_left = 1'b1;
    avail_bottomleft = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb_valid = 1'b1;
    nb_data = sample_t'(100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nb_data = sample_t'(200 + i);
    end
    check("s5.state_before_reset", dbg_state, ST_LOAD_TOP);
    nb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("s5.out_valid", out_valid, 0);
    check("s5.nb_ready", nb_ready, 0);
    check("s5.busy", busy, 0);
    set_zero_exp();
    check_arrays("s5");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5.no_valid_after", out_valid, 0);

    // scenario 1 again after the aborted block
    load_s1_stim_exp();
    run_block("s5b", 4, 4, 5'b11111, 1'b0, 146, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
